// File: rtl/bla_div_pkg.sv
// Shared types and helpers for the bla_div_seq sequential divider.
//   div_state_t : FSM state encoding (IDLE, CALC, DONE)
//   DEF_WIDTH   : default operand width
//   DEF_CNT_W   : default iteration counter width (2**DEF_CNT_W > DEF_WIDTH)
//   all_ones()  : all-ones value of a given width, used as divide-by-zero quotient
package bla_div_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic [31:0] all_ones(input int width);
        logic [32:0] one_hot;
        one_hot = 33'd1 << width;
        return 32'(one_hot - 33'd1);
    endfunction

endpackage

// File: rtl/bla_sub.sv
// Combinational N-bit borrow-lookahead subtractor: diff = a - b, borrow-in 0.
// Ports:
//   a, b  : N-bit unsigned operands
//   diff  : N-bit difference (modulo 2**N)
//   bout  : borrow out, high when a < b
module bla_sub #(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   brw;
    logic         term;
    logic         acc;

    // Every borrow is formed directly from generate/propagate terms:
    // brw[i+1] = OR over j<=i of (gen[j] AND prop[j+1..i]).
    always_comb begin
        gen  = ~a & b;
        prop = ~(a ^ b);
        brw  = '0;
        term = 1'b0;
        acc  = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                acc = acc | term;
            end
            brw[i+1] = acc;
        end
        diff = a ^ b ^ brw[N-1:0];
        bout = brw[N];
    end

endmodule

// File: rtl/bla_div_seq.sv
// Unsigned sequential restoring divider, one quotient bit per clock, with
// valid/ready handshakes on operands and result.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   dividend, divisor     : WIDTH-bit unsigned operands, sampled on accept
//   out_valid / out_ready : result handshake (out_valid high only in DONE)
//   quotient, remainder   : registered results, stable while out_valid
//   div_by_zero           : result was produced with divisor == 0
// Build option:
//   BLA_DIV_BYPASS_EN : when defined, dividend < divisor finishes at accept
//                       with quotient 0 and remainder = dividend.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// CALC  | one restoring step per cycle, counter runs WIDTH-1 down to 0
// DONE  | result presented, held until out_ready
module bla_div_seq
    import bla_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   t_val;
    logic [WIDTH:0]   d_val;
    logic [WIDTH:0]   sub_diff;
    logic             sub_bout;
    logic [WIDTH-1:0] r_sub;
    logic             diff_msb_unused;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign t_val = {r_reg, q_reg[WIDTH-1]};
    assign d_val = {1'b0, d_reg};

    bla_sub #(.N(WIDTH + 1)) u_sub (
        .a    (t_val),
        .b    (d_val),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    // When the subtract succeeds the result is below the divisor, so the
    // top bit is always zero and only the low WIDTH bits are kept.
    assign r_sub           = sub_diff[WIDTH-1:0];
    assign diff_msb_unused = sub_diff[WIDTH];

`ifdef BLA_DIV_BYPASS_EN
    logic [WIDTH-1:0] byp_diff_unused;
    logic             byp_lt;

    bla_sub #(.N(WIDTH)) u_byp (
        .a    (dividend),
        .b    (divisor),
        .diff (byp_diff_unused),
        .bout (byp_lt)
    );
`endif

    assign quotient  = q_reg;
    assign remainder = r_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        d_reg       <= divisor;
                        cnt         <= CNT_W'(WIDTH - 1);
                        div_by_zero <= (divisor == '0);
                        in_ready    <= 1'b0;
                        if (divisor == '0) begin
                            q_reg     <= WIDTH'(all_ones(WIDTH));
                            r_reg     <= dividend;
                            out_valid <= 1'b1;
                            state     <= DONE;
`ifdef BLA_DIV_BYPASS_EN
                        end else if (byp_lt) begin
                            q_reg     <= '0;
                            r_reg     <= dividend;
                            out_valid <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            q_reg <= dividend;
                            r_reg <= '0;
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    q_reg <= {q_reg[WIDTH-2:0], ~sub_bout};
                    r_reg <= sub_bout ? t_val[WIDTH-1:0] : r_sub;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
